// File: rtl/ahblite_sys.sv
// AHB-Lite demo system: hardwired counter master, decoder, zero-wait RAM,
// default (ERROR) slave and an 8-bit LED register, all on one clock.
module ahblite_sys #(
  parameter int DELAY_CYCLES = 4,
  parameter int RAM_WORDS    = 256
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic [7:0] LED
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam logic [31:0] LED_ADDR = 32'h5000_0000;

  typedef enum logic [1:0] {SEL_DEF, SEL_RAM, SEL_LED} sel_t;
  typedef enum logic [2:0] {S_INIT, S_RD, S_WR_RAM, S_WR_LED, S_WAIT} state_t;

  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  state_t      state;
  logic        dphase;
  logic [31:0] r;
  logic [7:0]  wait_cnt;

  sel_t        sel_dp;
  logic        act_dp;
  logic        ds_done;
  logic        write_dp;
  logic        word_dp;
  logic [AW-1:0] addr_dp;
  logic [7:0]  led_reg;
  logic [31:0] mem [RAM_WORDS];
  sel_t        sel_ap;

  // Master drives: address phase is NONSEQ, data phase and WAIT are IDLE.
  assign htrans = (!dphase && state != S_WAIT && !RESET) ? 2'b10 : 2'b00;
  assign haddr  = (state == S_WR_LED) ? LED_ADDR : 32'h0000_0000;
  assign hwrite = (state != S_RD);
  assign hsize  = 3'b010;
  assign hwdata = (state == S_INIT) ? 32'h0000_0000 : r + 32'd1;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= S_INIT;
      dphase   <= 1'b0;
      r        <= 32'h0000_0000;
      wait_cnt <= 8'd0;
    end else if (state == S_WAIT) begin
      if (int'(wait_cnt) == DELAY_CYCLES - 1) state <= S_RD;
      wait_cnt <= wait_cnt + 8'd1;
    end else if (!dphase) begin
      if (hready) dphase <= 1'b1;
    end else if (hready) begin
      dphase <= 1'b0;
      if (hresp) begin
        state <= S_RD;
      end else begin
        case (state)
          S_INIT:   state <= S_RD;
          S_RD: begin
            r     <= hrdata;
            state <= S_WR_RAM;
          end
          S_WR_RAM: state <= S_WR_LED;
          S_WR_LED: begin
            wait_cnt <= 8'd0;
            state    <= (DELAY_CYCLES == 0) ? S_RD : S_WAIT;
          end
          default:  state <= S_RD;
        endcase
      end
    end
  end

  always_comb begin
    sel_ap = SEL_DEF;
    if (haddr[31:AW+2] == '0)  sel_ap = SEL_RAM;
    else if (haddr == LED_ADDR) sel_ap = SEL_LED;
  end

  // Address phase -> data phase: slave select and transfer attributes.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sel_dp <= SEL_DEF;
      act_dp <= 1'b0;
    end else if (hready) begin
      sel_dp <= sel_ap;
      act_dp <= htrans[1];
    end
  end

  always_ff @(posedge CLK) begin
    if (hready) begin
      write_dp <= hwrite;
      word_dp  <= (hsize == 3'b010);
      addr_dp  <= haddr[AW+1:2];
    end
  end

  // Default slave: first data cycle stalls with ERROR, second completes it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)       ds_done <= 1'b0;
    else if (hready) ds_done <= 1'b0;
    else             ds_done <= 1'b1;
  end

  assign hresp  = (sel_dp == SEL_DEF) && act_dp;
  assign hready = !(hresp && !ds_done);

  always_ff @(posedge CLK) begin
    if (sel_dp == SEL_RAM && act_dp && write_dp && word_dp)
      mem[addr_dp] <= hwdata;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) led_reg <= 8'h00;
    else if (sel_dp == SEL_LED && act_dp && write_dp && word_dp)
      led_reg <= hwdata[7:0];
  end

  always_comb begin
    hrdata = 32'h0000_0000;
    case (sel_dp)
      SEL_RAM: hrdata = mem[addr_dp];
      SEL_LED: hrdata = {24'h000000, led_reg};
      default: hrdata = 32'h0000_0000;
    endcase
  end

  assign LED = led_reg;
endmodule

// File: tb/tb_ahblite_sys.sv
// Directed bench for ahblite_sys: update timing, wrap, async reset,
// default-slave error recovery and a zero-delay bus probe.
module tb_ahblite_sys;
  logic       clk;
  logic       rst;
  logic       rst_z;
  logic [7:0] led;
  logic [7:0] led_z;
  int total;
  int bad;

  ahblite_sys #(.DELAY_CYCLES(4), .RAM_WORDS(256)) dut (
    .CLK(clk), .RESET(rst), .LED(led)
  );
  ahblite_sys #(.DELAY_CYCLES(0), .RAM_WORDS(256)) dut_z (
    .CLK(clk), .RESET(rst_z), .LED(led_z)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int viol_alt;
    int viol_size;
    int reads;
    logic [1:0] prev;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    rst_z = 1'b1;

    #30;
    chk("rst_led", 32'(led), 32'h00);
    #20 rst = 1'b0;

    // Release at 50 ns; edge 1 is at 55 ns.
    edges(7);
    chk("pre_edge8", 32'(led), 32'h00);
    edges(1);
    chk("edge8", 32'(led), 32'h01);
    chk("ram0_first", dut.mem[0], 32'h0000_0001);

    for (int k = 2; k <= 5; k++) begin
      edges(9);
      chk("hold", 32'(led), 32'(k - 1));
      edges(1);
      chk("step", 32'(led), 32'(k));
    end

    // Run up to update 255, then the wrapping update 256.
    edges(2500);
    chk("upd255", 32'(led), 32'hFF);
    edges(10);
    chk("wrap", 32'(led), 32'h00);
    chk("ram0_wrap", dut.mem[0], 32'h0000_0100);
    edges(10);
    chk("upd257", 32'(led), 32'h01);

    // WR_RAM data phase is the cycle ending 8 edges after an LED update.
    edges(7);
    #2 rst = 1'b1;
    #1 chk("async_clr", 32'(led), 32'h00);
    @(posedge clk);
    #3 rst = 1'b0;
    edges(7);
    chk("rst_hold", 32'(led), 32'h00);
    edges(1);
    chk("rst_restart", 32'(led), 32'h01);
    chk("ram0_reinit", dut.mem[0], 32'h0000_0001);

    // RD address phase sits between LED edge +4 and +5; misroute it.
    edges(4);
    force dut.haddr = 32'h2000_0000;
    edges(1);
    release dut.haddr;
    chk("err1_ready", 32'(dut.hready), 32'h0);
    chk("err1_resp", 32'(dut.hresp), 32'h1);
    edges(1);
    chk("err2_ready", 32'(dut.hready), 32'h1);
    chk("err2_resp", 32'(dut.hresp), 32'h1);
    edges(6);
    chk("err_hold", 32'(led), 32'h01);
    edges(1);
    chk("err_resume", 32'(led), 32'h02);
    edges(10);
    chk("err_next", 32'(led), 32'h03);

    // Zero-delay instance.
    rst_z = 1'b0;
    edges(7);
    chk("z_pre8", 32'(led_z), 32'h00);
    edges(1);
    chk("z_edge8", 32'(led_z), 32'h01);
    for (int k = 2; k <= 4; k++) begin
      edges(5);
      chk("z_hold", 32'(led_z), 32'(k - 1));
      edges(1);
      chk("z_step", 32'(led_z), 32'(k));
    end

    viol_alt  = 0;
    viol_size = 0;
    reads     = 0;
    prev      = dut_z.htrans;
    for (int c = 0; c < 30; c++) begin
      edges(1);
      if (dut_z.htrans == prev) viol_alt++;
      if (dut_z.htrans != 2'b10 && dut_z.htrans != 2'b00) viol_alt++;
      if (dut_z.htrans == 2'b10 && dut_z.hsize != 3'b010) viol_size++;
      if (dut_z.htrans == 2'b10 && !dut_z.hwrite) begin
        reads++;
        if (dut_z.haddr != 32'h0) viol_size++;
      end
      prev = dut_z.htrans;
    end
    chk("z_alternate", 32'(viol_alt), 32'd0);
    chk("z_size", 32'(viol_size), 32'd0);
    chk("z_reads", 32'(reads), 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
